// File: rtl/riscv_internal_types.sv
// Shared RV32 internal types: the muldiv op code, funct3 subops and the
// iterative muldiv state encoding.
package riscv_internal_types;

  localparam logic [3:0] riscv_op_muldiv = 4'hb;

  localparam logic [3:0] riscv_subop_mul    = 4'd0;
  localparam logic [3:0] riscv_subop_mulh   = 4'd1;
  localparam logic [3:0] riscv_subop_mulhsu = 4'd2;
  localparam logic [3:0] riscv_subop_mulhu  = 4'd3;
  localparam logic [3:0] riscv_subop_div    = 4'd4;
  localparam logic [3:0] riscv_subop_divu   = 4'd5;
  localparam logic [3:0] riscv_subop_rem    = 4'd6;
  localparam logic [3:0] riscv_subop_remu   = 4'd7;

  typedef enum logic [1:0] {
    muldiv_idle = 2'd0,
    muldiv_busy = 2'd1,
    muldiv_done = 2'd2
  } t_muldiv_iter_state;

endpackage

// File: rtl/riscv_i32_muldiv_iter_step.sv
// One iteration of the muldiv datapath: shift-add multiply of MUL_BITS
// multiplier bits, or DIV_BITS restoring-divide quotient bits.
module riscv_i32_muldiv_iter_step #(
  parameter int MUL_BITS = 4,
  parameter int DIV_BITS = 1
) (
  input  logic        is_div,
  input  logic [63:0] acc_in,
  input  logic [63:0] opa_in,
  input  logic [31:0] opb_in,
  output logic [63:0] acc_out,
  output logic [63:0] opa_out,
  output logic [31:0] opb_out
);

  logic [63:0] mul_sum;
  logic [31:0] div_rem;
  logic [31:0] div_quo;
  logic [32:0] div_trial;

  // Multiply: acc is the product, opa the pre-shifted multiplicand, opb the
  // remaining multiplier. Divide: acc = {remainder, dividend/quotient}, opa = divisor.
  always_comb begin
    mul_sum = acc_in;
    for (int b = 0; b < MUL_BITS; b++) begin
      if (opb_in[b]) mul_sum = mul_sum + (opa_in << b);
    end
    div_rem   = acc_in[63:32];
    div_quo   = acc_in[31:0];
    div_trial = '0;
    for (int b = 0; b < DIV_BITS; b++) begin
      div_trial = {div_rem, div_quo[31]};
      if (div_trial >= {1'b0, opa_in[31:0]}) begin
        div_trial = div_trial - {1'b0, opa_in[31:0]};
        div_quo   = {div_quo[30:0], 1'b1};
      end else begin
        div_quo   = {div_quo[30:0], 1'b0};
      end
      div_rem = div_trial[31:0];
    end
    if (is_div) begin
      acc_out = {div_rem, div_quo};
      opa_out = opa_in;
      opb_out = opb_in;
    end else begin
      acc_out = mul_sum;
      opa_out = opa_in << MUL_BITS;
      opb_out = opb_in >> MUL_BITS;
    end
  end

endmodule

// File: rtl/riscv_i32_muldiv_iter.sv
// Iterative RV32M multiply/divide coprocessor returning its result in the
// ALU stage through the cannot_start/cannot_complete stall handshake.
module riscv_i32_muldiv_iter
  import riscv_internal_types::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 4,
  parameter int DIV_BITS_PER_CYCLE = 1,
  parameter bit EARLY_TERMINATE    = 1'b1
) (
  input  logic               clk,
  input  logic               clk__enable,
  input  logic               reset_n,
  input  logic               riscv_config__i32m,
  input  logic               coproc_controls__dec_idecode_valid,
  input  logic [3:0]         coproc_controls__dec_idecode__op,
  input  logic [3:0]         coproc_controls__dec_idecode__subop,
  input  logic               coproc_controls__dec_to_alu_blocked,
  input  logic [31:0]        coproc_controls__alu_rs1,
  input  logic [31:0]        coproc_controls__alu_rs2,
  input  logic               coproc_controls__alu_flush_pipeline,
  input  logic               coproc_controls__alu_cannot_start,
  input  logic               coproc_controls__alu_cannot_complete,
  output logic               coproc_response__cannot_start,
  output logic               coproc_response__cannot_complete,
  output logic [31:0]        coproc_response__result,
  output logic               coproc_response__result_valid,
  output t_muldiv_iter_state debug_state
);

  localparam logic [5:0] MUL_LAST = 6'(32 / MUL_BITS_PER_CYCLE - 1);
  localparam logic [5:0] DIV_LAST = 6'(32 / DIV_BITS_PER_CYCLE - 1);

  t_muldiv_iter_state state, state_next;
  logic        alu_valid, alu_valid_next;
  logic [3:0]  subop, subop_next;
  logic [63:0] acc, acc_next, opa, opa_next, step_acc, step_opa, prod;
  logic [31:0] opb, opb_next, step_opb, div_sel, div_fix, rs1, rs2, rs1_mag, rs2_mag;
  logic [5:0]  cnt, cnt_next;
  logic        neg, neg_next, flush, claim, rs1_neg, rs2_neg, div_zero, div_ovf;
  logic        is_div, rs1_signed, rs2_signed, want_rem, want_low;

  assign rs1   = coproc_controls__alu_rs1;
  assign rs2   = coproc_controls__alu_rs2;
  assign flush = coproc_controls__alu_flush_pipeline;

  always_comb begin
    is_div = 1'b0; rs1_signed = 1'b0; rs2_signed = 1'b0; want_rem = 1'b0; want_low = 1'b0;
    case (subop)
      riscv_subop_mul:    want_low = 1'b1;
      riscv_subop_mulh:   begin rs1_signed = 1'b1; rs2_signed = 1'b1; end
      riscv_subop_mulhsu: rs1_signed = 1'b1;
      riscv_subop_div:    begin is_div = 1'b1; rs1_signed = 1'b1; rs2_signed = 1'b1; end
      riscv_subop_divu:   is_div = 1'b1;
      riscv_subop_rem:    begin is_div = 1'b1; want_rem = 1'b1; rs1_signed = 1'b1; rs2_signed = 1'b1; end
      riscv_subop_remu:   begin is_div = 1'b1; want_rem = 1'b1; end
      default:            ;
    endcase
  end

  assign rs1_neg  = rs1_signed & rs1[31];
  assign rs2_neg  = rs2_signed & rs2[31];
  assign rs1_mag  = rs1_neg ? -rs1 : rs1;
  assign rs2_mag  = rs2_neg ? -rs2 : rs2;
  assign div_zero = (rs2 == 32'h0);
  assign div_ovf  = rs2_signed & (rs1 == 32'h8000_0000) & (rs2 == 32'hffff_ffff);

  riscv_i32_muldiv_iter_step #(
    .MUL_BITS(MUL_BITS_PER_CYCLE),
    .DIV_BITS(DIV_BITS_PER_CYCLE)
  ) u_step (
    .is_div (is_div),
    .acc_in (acc),
    .opa_in (opa),
    .opb_in (opb),
    .acc_out(step_acc),
    .opa_out(step_opa),
    .opb_out(step_opb)
  );

  always_comb begin
    state_next = state;
    acc_next   = acc;
    opa_next   = opa;
    opb_next   = opb;
    cnt_next   = cnt;
    neg_next   = neg;
    case (state)
      muldiv_idle: begin
        if (alu_valid && !coproc_controls__alu_cannot_start && !flush) begin
          neg_next = (is_div && want_rem) ? rs1_neg : (rs1_neg ^ rs2_neg);
          cnt_next = is_div ? DIV_LAST : MUL_LAST;
          if (is_div && div_zero) begin
            acc_next   = {rs1, 32'hffff_ffff};
            neg_next   = 1'b0;
            state_next = muldiv_done;
          end else if (is_div && div_ovf) begin
            acc_next   = {32'h0, 32'h8000_0000};
            neg_next   = 1'b0;
            state_next = muldiv_done;
          end else if (is_div) begin
            acc_next   = {32'h0, rs1_mag};
            opa_next   = {32'h0, rs2_mag};
            state_next = muldiv_busy;
          end else begin
            acc_next   = '0;
            opa_next   = {32'h0, rs1_mag};
            opb_next   = rs2_mag;
            state_next = muldiv_busy;
          end
        end
      end
      muldiv_busy: begin
        if (flush) begin
          state_next = muldiv_idle;
        end else begin
          acc_next = step_acc;
          opa_next = step_opa;
          opb_next = step_opb;
          cnt_next = cnt - 6'd1;
          // Early exit once no multiplier bits remain to be added in.
          if (cnt == 6'd0 || (EARLY_TERMINATE && !is_div && step_opb == 32'h0))
            state_next = muldiv_done;
        end
      end
      muldiv_done: begin
        if (flush || !coproc_controls__alu_cannot_complete) state_next = muldiv_idle;
      end
      default: state_next = muldiv_idle;
    endcase
  end

  // Handshake: an instruction enters the ALU stage (alu_valid) only while the
  // pipeline is not blocked; cannot_start holds new entry off while busy, and
  // cannot_complete stalls the ALU-stage instruction until result_valid.
  assign claim = coproc_controls__dec_idecode_valid && riscv_config__i32m &&
                 (coproc_controls__dec_idecode__op == riscv_op_muldiv) &&
                 !coproc_controls__dec_to_alu_blocked;

  always_comb begin
    alu_valid_next = alu_valid;
    subop_next     = subop;
    if (flush) begin
      alu_valid_next = 1'b0;
    end else if (claim) begin
      alu_valid_next = 1'b1;
      subop_next     = coproc_controls__dec_idecode__subop;
    end else if (state == muldiv_done && state_next == muldiv_idle) begin
      alu_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= muldiv_idle;
      alu_valid <= 1'b0;
      subop     <= '0;
      acc       <= '0;
      opa       <= '0;
      opb       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
    end else if (clk__enable) begin
      state     <= state_next;
      alu_valid <= alu_valid_next;
      subop     <= subop_next;
      acc       <= acc_next;
      opa       <= opa_next;
      opb       <= opb_next;
      cnt       <= cnt_next;
      neg       <= neg_next;
    end
  end

  // Quotient and remainder are negated independently as 32-bit values.
  assign prod    = neg ? -acc : acc;
  assign div_sel = want_rem ? acc[63:32] : acc[31:0];
  assign div_fix = neg ? -div_sel : div_sel;

  assign coproc_response__result_valid    = (state == muldiv_done) && !flush;
  assign coproc_response__cannot_start    = (state != muldiv_idle);
  assign coproc_response__cannot_complete = alu_valid && (state != muldiv_done);
  assign coproc_response__result = !coproc_response__result_valid ? 32'h0 :
                                   is_div   ? div_fix :
                                   want_low ? prod[31:0] : prod[63:32];
  assign debug_state = state;

endmodule
